// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals for i2c_txn_arbiter.
// "master" is the arbiter's view; "slave" is the view of whatever drives it.
interface i2c_txn_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  req_read;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        m_read;
  logic [6:0]  m_slave_address;
  logic [7:0]  m_data_send;
  logic        m_data_send_enable;
  logic [7:0]  m_data_receive;
  logic        m_data_receive_enable;
  logic        m_xfer_done;
  logic        m_error;

  modport master (
    input  req, req_read, req_addr, req_wdata,
    output gnt, done, rsp_data, rsp_error, busy,
    output m_read, m_slave_address, m_data_send, m_data_send_enable,
    input  m_data_receive, m_data_receive_enable, m_xfer_done, m_error
  );

  modport slave (
    output req, req_read, req_addr, req_wdata,
    input  gnt, done, rsp_data, rsp_error, busy,
    input  m_read, m_slave_address, m_data_send, m_data_send_enable,
    output m_data_receive, m_data_receive_enable, m_xfer_done, m_error
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter serializing 4 requesters onto one I2C master, one transaction at a time.
// Optional WAIT-state watchdog enabled by defining I2C_ARB_TIMEOUT_EN (length TIMEOUT_CYCLES).
module i2c_txn_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  i2c_txn_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  win_q, win_d;
  logic        rd_q, rd_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        err_q, err_d;

  logic [1:0]  pick;
  logic        pick_vld;
  logic        ok_pulse;
  logic        fin;
  logic        tmo_hit;

  // Walk from the highest offset down so the first set bit at/after ptr wins.
  always_comb begin
    logic [1:0] idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + k[1:0];
      if (bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Only the pulse matching the latched direction counts; error always completes.
  assign ok_pulse = rd_q ? bus.m_data_receive_enable : bus.m_xfer_done;
  assign fin      = bus.m_error | ok_pulse;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == LAUNCH)    tmo_d = '0;
    else if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = LAUNCH;
        win_d   = pick;
        ptr_d   = pick + 2'd1;
        rd_d    = bus.req_read[pick];
        addr_d  = bus.req_addr[7*pick +: 7];
        wdat_d  = bus.req_wdata[8*pick +: 8];
        rdat_d  = '0;
        err_d   = 1'b0;
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (fin) begin
          state_d = RESP;
          err_d   = bus.m_error;
          rdat_d  = (rd_q && !bus.m_error) ? bus.m_data_receive : 8'h00;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdat_d  = 8'h00;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt                = '0;
    bus.done               = '0;
    bus.m_data_send_enable = 1'b0;
    bus.busy               = (state_q != IDLE);
    case (state_q)
      LAUNCH: begin
        bus.gnt[win_q]         = 1'b1;
        bus.m_data_send_enable = 1'b1;
      end
      WAIT: bus.gnt[win_q] = 1'b1;
      RESP: begin
        bus.gnt[win_q]  = 1'b1;
        bus.done[win_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.m_read          = rd_q;
  assign bus.m_slave_address = addr_q;
  assign bus.m_data_send     = wdat_q;
  assign bus.rsp_data        = rdat_q;
  assign bus.rsp_error       = err_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: write/read paths, rotation, error, reset abort, watchdog.
module tb_i2c_txn_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  i2c_txn_arbiter_if bus ();

  i2c_txn_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_in();
    bus.req                   = '0;
    bus.req_read              = '0;
    bus.req_addr              = '0;
    bus.req_wdata             = '0;
    bus.m_data_receive        = '0;
    bus.m_data_receive_enable = 1'b0;
    bus.m_xfer_done           = 1'b0;
    bus.m_error               = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    clr_in();
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_gnt",  bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_en",   bus.m_data_send_enable, 0);
    chk("rst_rsp",  {bus.rsp_error, bus.rsp_data}, 0);
    chk("rst_addr", {bus.m_read, bus.m_slave_address, bus.m_data_send}, 0);
    rst = 1'b0;
    cyc();

    // Write from requester 0; req dropped right after grant must not abort.
    bus.req = 4'b0001; bus.req_addr[6:0] = 7'h50; bus.req_wdata[7:0] = 8'hA5;
    cyc();
    chk("w_gnt",  bus.gnt, 4'b0001);
    chk("w_en",   bus.m_data_send_enable, 1);
    chk("w_addr", bus.m_slave_address, 7'h50);
    chk("w_data", bus.m_data_send, 8'hA5);
    chk("w_rd",   bus.m_read, 0);
    bus.req = 4'b0000;
    cyc();
    chk("w_en_1shot", bus.m_data_send_enable, 0);
    chk("w_gnt_wait", bus.gnt, 4'b0001);
    bus.m_data_receive_enable = 1'b1;
    cyc();
    bus.m_data_receive_enable = 1'b0;
    chk("w_ign_rxen", bus.done, 0);
    bus.m_xfer_done = 1'b1;
    cyc();
    bus.m_xfer_done = 1'b0;
    chk("w_done", bus.done, 4'b0001);
    chk("w_err",  bus.rsp_error, 0);
    chk("w_rdat", bus.rsp_data, 0);
    cyc();
    chk("w_idle_gnt",  bus.gnt, 0);
    chk("w_idle_busy", bus.busy, 0);
    chk("w_idle_done", bus.done, 0);

    // Read from requester 2; inputs changed after launch must not leak through.
    bus.req = 4'b0100; bus.req_read = 4'b0100; bus.req_addr[20:14] = 7'h3C;
    cyc();
    chk("r_gnt",  bus.gnt, 4'b0100);
    chk("r_rd",   bus.m_read, 1);
    chk("r_addr", bus.m_slave_address, 7'h3C);
    bus.req = '0; bus.req_read = '0; bus.req_addr = '1;
    cyc();
    chk("r_addr_hold", bus.m_slave_address, 7'h3C);
    bus.m_xfer_done = 1'b1;
    cyc();
    bus.m_xfer_done = 1'b0;
    chk("r_ign_xfer", bus.done, 0);
    bus.m_data_receive = 8'h5E; bus.m_data_receive_enable = 1'b1;
    cyc();
    bus.m_data_receive_enable = 1'b0;
    chk("r_done", bus.done, 4'b0100);
    chk("r_rdat", bus.rsp_data, 8'h5E);
    chk("r_err",  bus.rsp_error, 0);
    clr_in();
    cyc();
    // Completion pulses in IDLE must be ignored.
    bus.m_xfer_done = 1'b1; bus.m_error = 1'b1;
    cyc();
    clr_in();
    chk("idle_ign", {bus.busy, bus.done}, 0);

    // Read with error and success in the same cycle; ptr is 3, req0 wins.
    bus.req = 4'b0001; bus.req_read = 4'b0001;
    cyc();
    chk("e_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    cyc();
    bus.m_error = 1'b1; bus.m_data_receive_enable = 1'b1; bus.m_data_receive = 8'h77;
    cyc();
    clr_in();
    chk("e_done", bus.done, 4'b0001);
    chk("e_err",  bus.rsp_error, 1);
    cyc();

    // Rotation with all requests held, starting from a fresh pointer.
    rst = 1'b1; cyc(); rst = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("rr_gnt%0d", i), bus.gnt, 32'(4'b0001 << (i % 4)));
      cyc();
      bus.m_xfer_done = 1'b1;
      cyc();
      bus.m_xfer_done = 1'b0;
      chk($sformatf("rr_done%0d", i), bus.done, 32'(4'b0001 << (i % 4)));
      cyc();
    end
    bus.req = '0;
    cyc();

    // Reset in WAIT: outputs clear asynchronously, pointer returns to 0.
    bus.req = 4'b0100; bus.req_addr[20:14] = 7'h11; bus.req_wdata[23:16] = 8'h22;
    cyc();
    chk("a_gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("a_gnt0",  bus.gnt, 0);
    chk("a_busy0", bus.busy, 0);
    chk("a_done0", bus.done, 0);
    chk("a_m0",    {bus.m_read, bus.m_slave_address, bus.m_data_send, bus.m_data_send_enable}, 0);
    bus.m_xfer_done = 1'b1;
    cyc(); cyc();
    bus.m_xfer_done = 1'b0;
    rst = 1'b0;
    cyc();
    chk("a_nodone", bus.done, 0);
    bus.req = 4'b1010;
    cyc();
    chk("a_ptr0", bus.gnt, 4'b0010);
    bus.req = '0;
    cyc();
    bus.m_xfer_done = 1'b1;
    cyc();
    bus.m_xfer_done = 1'b0;
    chk("a_done", bus.done, 4'b0010);
    cyc();

    // Transaction that never completes.
    bus.req = 4'b0001;
    cyc();
    bus.req = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    n = 0;
    while (n < 40) begin
      cyc();
      n++;
      if (bus.done != 0) break;
    end
    chk("to_lat",  n, 17);
    chk("to_done", bus.done, 4'b0001);
    chk("to_err",  bus.rsp_error, 1);
    chk("to_rdat", bus.rsp_data, 0);
`else
    seen = 0;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (bus.done != 0) seen++;
    end
    chk("nto_done", seen, 0);
    chk("nto_busy", bus.busy, 1);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, shall set WAIT-state cycles before forced error completion (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester transaction request, level.
REQ-005 req_read  input  4  per-requester direction: 1=read, 0=write.
REQ-006 req_addr  input  28  packed 7-bit slave addresses; requester i at [7i+6:7i].
REQ-007 req_wdata  input  32  packed write bytes; requester i at [8i+7:8i].
REQ-008 gnt  output  4  one-hot grant, high from launch through completion.
REQ-009 done  output  4  one-cycle completion pulse to granted requester.
REQ-010 rsp_data  output  8  read byte, valid in the cycle done is high.
REQ-011 rsp_error  output  1  error flag, valid in the cycle done is high.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 m_read  output  1  to master read input.
REQ-014 m_slave_address  output  7  to master slave_address.
REQ-015 m_data_send  output  8  to master data_send_master.
REQ-016 m_data_send_enable  output  1  one-cycle transaction start pulse to master.
REQ-017 m_data_receive  input  8  from master data_receive_master.
REQ-018 m_data_receive_enable  input  1  read-completion pulse from master.
REQ-019 m_xfer_done  input  1  write-completion pulse from master-side wrapper.
REQ-020 m_error  input  1  master error_master.

Function
REQ-021 FSM states shall be IDLE, LAUNCH, WAIT, RESP; IDLE->LAUNCH on any req bit; LAUNCH->WAIT unconditionally; WAIT->RESP on completion; RESP->IDLE unconditionally.
REQ-022 Arbitration in IDLE shall be round-robin: search starts at pointer p (reset 0), first set req bit at or after p (mod 4) wins; p <= winner+1 mod 4 on grant.
REQ-023 Winner's read flag, address and wdata shall be registered in IDLE->LAUNCH; later changes to req_* shall not affect the transaction.
REQ-024 In LAUNCH, gnt[winner]=1 and m_data_send_enable=1 for exactly one cycle; m_read/m_slave_address/m_data_send hold registered values from LAUNCH through RESP.
REQ-025 Latency: req sampled high in IDLE at edge N -> gnt and m_data_send_enable high in cycle N+1.
REQ-026 Completion in WAIT: read -> m_data_receive_enable or m_error; write -> m_xfer_done or m_error; m_data_receive_enable ignored for writes, m_xfer_done ignored for reads.
REQ-027 On completion, m_data_receive shall be captured into rsp_data (reads only; writes give rsp_data=0); rsp_error=m_error sampled same cycle; m_error wins if simultaneous with a success pulse.
REQ-028 In RESP, done[winner]=1 for one cycle with rsp_data/rsp_error valid; gnt drops on RESP->IDLE.
REQ-029 Completion/error inputs outside WAIT shall be ignored.
REQ-030 Requester deasserting req after grant shall not abort; transaction still completes with done.
REQ-031 At least one IDLE cycle between transactions; back-to-back requests rotate per REQ-022.

Reset
REQ-032 rst high shall immediately force IDLE, p=0, and gnt, done, rsp_data, rsp_error, busy, m_read, m_slave_address, m_data_send, m_data_send_enable all 0, including mid-transaction; no done pulse for the aborted transaction.

Configuration
REQ-033 Macro I2C_ARB_TIMEOUT_EN defined: counter cleared on LAUNCH, incremented in WAIT; reaching TIMEOUT_CYCLES without completion forces WAIT->RESP with rsp_error=1, rsp_data=0.
REQ-034 I2C_ARB_TIMEOUT_EN undefined: no counter hardware; WAIT persists until completion or reset.

Verification
REQ-035 req=0001, req_read[0]=0, addr0=7'h50, wdata0=8'hA5 -> cycle after: gnt=0001, enable pulse, m_slave_address=50, m_data_send=A5; m_xfer_done -> next cycle done=0001, rsp_error=0.
REQ-036 req=0100 read, addr2=7'h3C; m_data_receive=8'h5E with m_data_receive_enable -> done=0100, rsp_data=5E, rsp_error=0.
REQ-037 req=1111 held after reset -> grants in order 0001,0010,0100,1000,0001 across five transactions.
REQ-038 Read with m_error and m_data_receive_enable in same cycle -> done with rsp_error=1.
REQ-039 With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no completion -> done after 16 WAIT cycles, rsp_error=1; without macro, no done after 10000 cycles.
REQ-040 rst asserted in WAIT -> all outputs 0 same cycle, no done; next req=0010 granted normally with p=0 search.
